// File: rtl/next_pc_unit_pkg.sv
// Shared definitions for the IF-stage next-PC logic: FSM encoding, alignment and default widths.
package next_pc_unit_pkg;

  localparam int NBITS_DEF     = 32;
  localparam int NBITSJUMP_DEF = 26;

  // Instructions are word aligned: targets carry INSTR_ALIGN zero LSBs.
  localparam int INSTR_ALIGN   = 2;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } pc_state_e;

endpackage : next_pc_unit_pkg

// File: rtl/next_pc_unit_pc_target_calc.sv
// Combinational J/JAL, JR/JALR and branch target generation with fixed priority jr > jump > branch.
// Zero latency; no flow control, valid_o simply reports that some redirect is requested.
module pc_target_calc
  import next_pc_unit_pkg::*;
#(
  parameter int NBITS     = NBITS_DEF,
  parameter int NBITSJUMP = NBITSJUMP_DEF
) (
  input  logic                 jump_i,
  input  logic [NBITSJUMP-1:0] jump_index_i,
  input  logic                 jump_reg_i,
  input  logic [NBITS-1:0]     jr_target_i,
  input  logic                 branch_taken_i,
  input  logic [NBITS-1:0]     branch_offset_i,
  input  logic [NBITS-1:0]     id_pc4_i,
  output logic [NBITS-1:0]     target_o,
  output logic                 valid_o
);

  localparam logic [NBITS-1:0] ALIGN_MASK = ~NBITS'((1 << INSTR_ALIGN) - 1);

  logic [NBITS-1:0] jump_tgt;
  logic [NBITS-1:0] branch_tgt;
  logic [NBITS-1:0] jr_tgt;

  // J-format keeps the region bits of the delay-slot PC and replaces the rest.
  assign jump_tgt   = {id_pc4_i[NBITS-1:NBITSJUMP+INSTR_ALIGN], jump_index_i, {INSTR_ALIGN{1'b0}}};
  assign branch_tgt = id_pc4_i + (branch_offset_i << INSTR_ALIGN);
  assign jr_tgt     = jr_target_i & ALIGN_MASK;

  assign valid_o = jump_reg_i | jump_i | branch_taken_i;

  always_comb begin
    target_o = branch_tgt;
    if (jump_reg_i) begin
      target_o = jr_tgt;
    end else if (jump_i) begin
      target_o = jump_tgt;
    end
  end

endmodule : pc_target_calc

// File: rtl/next_pc_unit.sv
// Registered fetch PC with stall/debug freeze, one-deep redirect buffer and sticky HALT.
// Redirects land on o_pc one edge later, or at the first unfrozen edge when frozen.
module next_pc_unit
  import next_pc_unit_pkg::*;
#(
  parameter int               NBITS     = NBITS_DEF,
  parameter int               NBITSJUMP = NBITSJUMP_DEF,
  parameter logic [NBITS-1:0] RESET_PC  = '0
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_enable,
  input  logic                 i_stall,
  input  logic                 i_halt,
  input  logic                 i_jump,
  input  logic [NBITSJUMP-1:0] i_jump_index,
  input  logic                 i_jump_reg,
  input  logic [NBITS-1:0]     i_jr_target,
  input  logic                 i_branch_taken,
  input  logic [NBITS-1:0]     i_branch_offset,
  input  logic [NBITS-1:0]     i_id_pc4,
  output logic [NBITS-1:0]     o_pc,
  output logic [NBITS-1:0]     o_pc4,
  output logic [NBITS-1:0]     o_pc8,
  output logic                 o_halted,
  output logic                 o_redirect_pend
);

  localparam logic [NBITS-1:0] INSTR_BYTES = NBITS'(1 << INSTR_ALIGN);

  pc_state_e        state_q, state_d;
  logic [NBITS-1:0] pc_q, pc_d;
  logic             pend_vld_q, pend_vld_d;
  logic [NBITS-1:0] pend_tgt_q, pend_tgt_d;

  logic [NBITS-1:0] tgt;
  logic             tgt_vld;
  logic             freeze;

  pc_target_calc #(
    .NBITS     (NBITS),
    .NBITSJUMP (NBITSJUMP)
  ) u_target_calc (
    .jump_i          (i_jump),
    .jump_index_i    (i_jump_index),
    .jump_reg_i      (i_jump_reg),
    .jr_target_i     (i_jr_target),
    .branch_taken_i  (i_branch_taken),
    .branch_offset_i (i_branch_offset),
    .id_pc4_i        (i_id_pc4),
    .target_o        (tgt),
    .valid_o         (tgt_vld)
  );

  assign freeze = i_stall | ~i_enable;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;

    case (state_q)
      ST_RUN: begin
        if (i_halt) begin
          state_d = ST_HALTED;
        end else if (!freeze) begin
          // A buffered redirect is older than anything arriving now, so it wins.
          if (pend_vld_q) begin
            pc_d       = pend_tgt_q;
            pend_vld_d = 1'b0;
          end else if (tgt_vld) begin
            pc_d = tgt;
          end else begin
            pc_d = pc_q + INSTR_BYTES;
          end
        end else if (tgt_vld && !pend_vld_q) begin
          pend_vld_d = 1'b1;
          pend_tgt_d = tgt;
        end
      end
      ST_HALTED: begin
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign o_pc            = pc_q;
  assign o_pc4           = pc_q + INSTR_BYTES;
  assign o_pc8           = pc_q + (INSTR_BYTES << 1);
  assign o_halted        = (state_q == ST_HALTED);
  assign o_redirect_pend = pend_vld_q;

endmodule : next_pc_unit

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit: expected PCs are queued as stimulus is driven and checked after each edge.
module tb_next_pc_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable, stall, halt, jump, jump_reg, branch_taken;
  logic [25:0] jump_index;
  logic [31:0] jr_target, branch_offset, id_pc4;
  logic [31:0] pc, pc4, pc8;
  logic        halted, redirect_pend;

  typedef struct {
    string       tag;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  next_pc_unit #(
    .NBITS     (32),
    .NBITSJUMP (26),
    .RESET_PC  (32'h0)
  ) dut (
    .i_clk           (clk),
    .i_reset_n       (reset_n),
    .i_enable        (enable),
    .i_stall         (stall),
    .i_halt          (halt),
    .i_jump          (jump),
    .i_jump_index    (jump_index),
    .i_jump_reg      (jump_reg),
    .i_jr_target     (jr_target),
    .i_branch_taken  (branch_taken),
    .i_branch_offset (branch_offset),
    .i_id_pc4        (id_pc4),
    .o_pc            (pc),
    .o_pc4           (pc4),
    .o_pc8           (pc8),
    .o_halted        (halted),
    .o_redirect_pend (redirect_pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_pc(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.pc  = exp;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_underflow", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk(e.tag, pc, e.pc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_req();
    halt          = 1'b0;
    jump          = 1'b0;
    jump_reg      = 1'b0;
    branch_taken  = 1'b0;
    jump_index    = '0;
    jr_target     = '0;
    branch_offset = '0;
    id_pc4        = '0;
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b1;
    stall   = 1'b0;
    clr_req();

    // Reset state
    #2;
    chk("reset_pc", pc, 32'h0);
    chk("reset_halted", {31'b0, halted}, 32'd0);
    chk("reset_pend", {31'b0, redirect_pend}, 32'd0);
    step();
    step();
    reset_n = 1'b1;
    expect_pc("post_reset_pc", 32'h0);
    pop_check();

    // Free run
    for (int i = 1; i <= 3; i++) begin
      expect_pc("free_run_pc", 32'(4 * i));
      step();
      pop_check();
    end
    chk("pc4_at_c", pc4, 32'h10);
    chk("pc8_at_c", pc8, 32'h14);

    // J target keeps region bits of id_pc4
    jump = 1'b1; jump_index = 26'h0000010; id_pc4 = 32'h4000_0008;
    expect_pc("jump_target", 32'h4000_0040);
    step(); clr_req();
    pop_check();
    expect_pc("after_jump_seq", 32'h4000_0044);
    step();
    pop_check();

    // Branch backward and wrap
    branch_taken = 1'b1; id_pc4 = 32'h100; branch_offset = 32'hFFFF_FFFE;
    expect_pc("branch_back", 32'hF8);
    step(); clr_req();
    pop_check();
    branch_taken = 1'b1; id_pc4 = 32'hFFFF_FFFC; branch_offset = 32'h1;
    expect_pc("branch_wrap", 32'h0);
    step(); clr_req();
    pop_check();

    // JR forces alignment; PC+4/PC+8 wrap
    jump_reg = 1'b1; jr_target = 32'hFFFF_FFFB;
    expect_pc("jr_align", 32'hFFFF_FFF8);
    step(); clr_req();
    pop_check();
    chk("pc4_wrap", pc4, 32'hFFFF_FFFC);
    chk("pc8_wrap", pc8, 32'h0);

    // Debug freeze via enable
    enable = 1'b0;
    expect_pc("enable_freeze", 32'hFFFF_FFF8);
    step();
    pop_check();
    enable = 1'b1;
    expect_pc("enable_resume", 32'hFFFF_FFFC);
    step();
    pop_check();

    // Stalled JR buffered, later branch dropped
    stall = 1'b1; jump_reg = 1'b1; jr_target = 32'h200;
    expect_pc("stall_hold1", 32'hFFFF_FFFC);
    step();
    pop_check();
    chk("pend_set", {31'b0, redirect_pend}, 32'd1);
    jump_reg = 1'b0; jr_target = '0;
    branch_taken = 1'b1; branch_offset = 32'h8; id_pc4 = 32'h1000;
    expect_pc("stall_hold2", 32'hFFFF_FFFC);
    step();
    pop_check();
    chk("pend_still_set", {31'b0, redirect_pend}, 32'd1);
    stall = 1'b0; clr_req();
    expect_pc("pend_release", 32'h200);
    step();
    pop_check();
    chk("pend_cleared", {31'b0, redirect_pend}, 32'd0);
    expect_pc("branch_dropped", 32'h204);
    step();
    pop_check();

    // Pending beats a new request on the release cycle
    stall = 1'b1; jump_reg = 1'b1; jr_target = 32'h300;
    expect_pc("stall_hold3", 32'h204);
    step();
    pop_check();
    stall = 1'b0; clr_req();
    jump = 1'b1; jump_index = 26'h55;
    expect_pc("pend_over_new", 32'h300);
    step(); clr_req();
    pop_check();
    expect_pc("after_pend_seq", 32'h304);
    step();
    pop_check();

    // Priority
    jump_reg = 1'b1; jr_target = 32'h500;
    jump = 1'b1; jump_index = 26'h10;
    branch_taken = 1'b1; branch_offset = 32'h4;
    expect_pc("prio_jr", 32'h500);
    step(); clr_req();
    pop_check();
    jump = 1'b1; jump_index = 26'h20; id_pc4 = 32'h1000_0000;
    branch_taken = 1'b1; branch_offset = 32'h4;
    expect_pc("prio_jump", 32'h1000_0080);
    step(); clr_req();
    pop_check();

    // Halt with a pending redirect held
    stall = 1'b1; jump_reg = 1'b1; jr_target = 32'h700;
    expect_pc("stall_hold4", 32'h1000_0080);
    step();
    pop_check();
    chk("pend_before_halt", {31'b0, redirect_pend}, 32'd1);
    stall = 1'b0; clr_req();
    halt = 1'b1; jump = 1'b1; jump_index = 26'h3;
    expect_pc("halt_pc", 32'h1000_0080);
    step(); clr_req();
    pop_check();
    chk("halted_set", {31'b0, halted}, 32'd1);
    chk("pend_in_halt", {31'b0, redirect_pend}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      jump         = i[0];
      jump_index   = 26'(i + 1);
      branch_taken = i[1];
      branch_offset = 32'h10;
      enable       = ~i[2];
      stall        = i[0] & i[1];
      expect_pc("halt_frozen_pc", 32'h1000_0080);
      step();
      pop_check();
      chk("halt_sticky", {31'b0, halted}, 32'd1);
    end
    clr_req();
    enable = 1'b1;
    stall  = 1'b0;

    // Async reset between edges while halted with pending
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_reset_pc", pc, 32'h0);
    chk("async_reset_halted", {31'b0, halted}, 32'd0);
    chk("async_reset_pend", {31'b0, redirect_pend}, 32'd0);
    #2;
    reset_n = 1'b1;
    expect_pc("run_after_reset", 32'h4);
    step();
    pop_check();

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_next_pc_unit
